// File: rtl/fft_spectrum_reader_pkg.sv
// fft_reader_pkg: shared types for the FFT spectrum reader
//   reader_state_e : IDLE -> CAPTURE -> DRAIN -> DONE -> IDLE
//   complex_t      : packed {re, im} bin sample, signed DEF_DATA_WIDTH each
package fft_reader_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} reader_state_e;
    typedef struct packed {
        logic signed [DEF_DATA_WIDTH-1:0] re;
        logic signed [DEF_DATA_WIDTH-1:0] im;
    } complex_t;
endpackage

// File: rtl/fft_spectrum_reader_if.sv
// fft_spectrum_reader_if: FFT output stream (valid/ready, data = {re, im})
//   master : drives valid, data; samples ready
//   slave  : samples valid, data; drives ready
interface fft_spectrum_reader_if
    import fft_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                    valid;
    logic [2*DATA_WIDTH-1:0] data;
    logic                    ready;
    modport master (output valid, data, input ready);
    modport slave  (input valid, data, output ready);
endinterface

// File: rtl/fft_pwr_calc.sv
// fft_pwr_calc: 2-stage |X|^2 pipeline; S1 squares re and im, S2 adds them
//   clk_i, rst_i (sync, active-high, clears valid pipeline)
//   valid_i, re_i, im_i -> valid_o, pwr_o (2 cycles later; invalid cycles leave data regs untouched)
module fft_pwr_calc #(
    parameter  int DATA_WIDTH = 16,
    localparam int PW = 2*DATA_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] re_i,
    input  logic signed [DATA_WIDTH-1:0] im_i,
    output logic                         valid_o,
    output logic [PW-1:0]                pwr_o
);
    logic signed [PW-1:0] re_sq_q, im_sq_q;
    logic                 s1_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            s1_valid_q <= valid_i;
            valid_o    <= s1_valid_q;
        end
    end

    // Squares are non-negative and at most 2^(2*DW-2), so their unsigned sum fits PW bits.
    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            re_sq_q <= PW'(re_i) * PW'(re_i);
            im_sq_q <= PW'(im_i) * PW'(im_i);
        end
        if (s1_valid_q) pwr_o <= $unsigned(re_sq_q) + $unsigned(im_sq_q);
    end
endmodule

// File: rtl/prim_ram.sv
// prim_ram: single-port RAM, registered read data, contents never cleared
//   clk_i, rst_ni (sync, active-low, clears rdata_o only)
//   req_i, we_i, addr_i, wdata_i : access request; rdata_o updates 1 cycle after a read, else holds
module prim_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (req_i && we_i) mem[addr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) rdata_o <= '0;
        else if (req_i && !we_i) rdata_o <= mem[addr_i];
    end
endmodule

// File: rtl/fft_spectrum_reader.sv
// fft_spectrum_reader: captures one FFT frame, stores per-bin |X|^2 in RAM, tracks the peak bin
//   clk_i, rst_i (sync, active-high); start_i arms capture from IDLE
//   fft_in (slave): bin stream, ready only in CAPTURE
//   busy_o, frame_done_o (1-cycle pulse), peak_bin_o, peak_pwr_o
//   rd_en_i, rd_addr_i -> rd_valid_o, rd_data_o (host reads, honoured only in IDLE)
//   Macro FFT_READER_HALF_SPECTRUM_EN: store/peak-search only bins 0..FFT_SIZE/2; higher reads return 0
module fft_spectrum_reader
    import fft_reader_pkg::*;
#(
    parameter  int FFT_SIZE   = 16,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int BW         = $clog2(FFT_SIZE),
    localparam int PWR_WIDTH  = 2*DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    fft_spectrum_reader_if.slave  fft_in,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [BW-1:0]         peak_bin_o,
    output logic [PWR_WIDTH-1:0]  peak_pwr_o,
    input  logic                  rd_en_i,
    input  logic [BW-1:0]         rd_addr_i,
    output logic [PWR_WIDTH-1:0]  rd_data_o,
    output logic                  rd_valid_o
);
    reader_state_e          state_q, state_d;
    logic [BW-1:0]          in_cnt_q, wr_bin_q;
    logic                   drain_q, accept, last_bin, pwr_valid, store, rd_in_range, rd_acc, rd_oob_q, wr_en;
    logic [PWR_WIDTH-1:0]   pwr, ram_rdata;

`ifdef FFT_READER_HALF_SPECTRUM_EN
    localparam int DEPTH = FFT_SIZE/2 + 1;
    assign store       = wr_bin_q <= BW'(FFT_SIZE/2);
    assign rd_in_range = rd_addr_i <= BW'(FFT_SIZE/2);
`else
    localparam int DEPTH = FFT_SIZE;
    assign store       = 1'b1;
    assign rd_in_range = 1'b1;
`endif

    assign accept    = fft_in.valid && fft_in.ready;
    assign last_bin  = accept && in_cnt_q == BW'(FFT_SIZE-1);
    assign wr_en     = pwr_valid && store;
    assign rd_acc    = rd_en_i && state_q == IDLE;
    assign rd_data_o = rd_oob_q ? '0 : ram_rdata;

    always_comb begin
        state_d      = state_q;
        fft_in.ready = state_q == CAPTURE;
        busy_o       = state_q != IDLE;
        frame_done_o = state_q == DONE;
        case (state_q)
            IDLE:    if (start_i) state_d = CAPTURE;
            CAPTURE: if (last_bin) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Bins arrive in order, so the write index is simply a count of pipeline outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            in_cnt_q   <= '0;
            wr_bin_q   <= '0;
            drain_q    <= 1'b0;
            peak_bin_o <= '0;
            peak_pwr_o <= '0;
            rd_valid_o <= 1'b0;
            rd_oob_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= state_q == DRAIN && !drain_q;
            rd_valid_o <= rd_acc;
            if (rd_acc) rd_oob_q <= !rd_in_range;
            if (state_q == IDLE && start_i) begin
                in_cnt_q   <= '0;
                wr_bin_q   <= '0;
                peak_bin_o <= '0;
                peak_pwr_o <= '0;
            end else begin
                if (accept) in_cnt_q <= in_cnt_q + 1'b1;
                if (pwr_valid) wr_bin_q <= wr_bin_q + 1'b1;
                if (wr_en && pwr > peak_pwr_o) begin
                    peak_bin_o <= wr_bin_q;
                    peak_pwr_o <= pwr;
                end
            end
        end
    end

    fft_pwr_calc #(.DATA_WIDTH(DATA_WIDTH)) u_pwr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (accept),
        .re_i    (fft_in.data[2*DATA_WIDTH-1:DATA_WIDTH]),
        .im_i    (fft_in.data[DATA_WIDTH-1:0]),
        .valid_o (pwr_valid),
        .pwr_o   (pwr)
    );

    // Writes happen only in CAPTURE/DRAIN and reads only in IDLE, so one port suffices.
    prim_ram #(.DEPTH(DEPTH), .WIDTH(PWR_WIDTH), .AW(BW)) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .req_i   (wr_en || (rd_acc && rd_in_range)),
        .we_i    (wr_en),
        .addr_i  (wr_en ? wr_bin_q : rd_addr_i),
        .wdata_i (pwr),
        .rdata_o (ram_rdata)
    );
endmodule

// File: tb/tb_fft_spectrum_reader.sv
// tb_fft_spectrum_reader: randomized frames checked against a per-bin power/peak model
module tb_fft_spectrum_reader;
    import fft_reader_pkg::*;
    localparam int N = 16, DW = 16, BW = 4, PW = 32;
`ifdef FFT_READER_HALF_SPECTRUM_EN
    localparam int HALF = 1;
`else
    localparam int HALF = 0;
`endif

    logic clk_i = 1'b0, rst_i, start_i, busy_o, frame_done_o, rd_en_i, rd_valid_o;
    logic [BW-1:0] peak_bin_o, rd_addr_i;
    logic [PW-1:0] peak_pwr_o, rd_data_o;

    fft_spectrum_reader_if #(.DATA_WIDTH(DW)) fft_if ();

    fft_spectrum_reader #(.FFT_SIZE(N), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .fft_in(fft_if),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .peak_bin_o(peak_bin_o), .peak_pwr_o(peak_pwr_o),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0, n_fail = 0, done_cnt = 0;
    int re_a[N], im_a[N];
    longint mem_m[N];

    always @(negedge clk_i) if (frame_done_o === 1'b1) done_cnt++;

    function automatic longint pwr_of(int i);
        return longint'(re_a[i]) * re_a[i] + longint'(im_a[i]) * im_a[i];
    endfunction

    function automatic bit stored(int i);
        return HALF == 0 || i <= N/2;
    endfunction

    function automatic logic [PW-1:0] exp_rd(int i);
        return stored(i) ? PW'(mem_m[i]) : '0;
    endfunction

    task automatic model_peak(output logic [BW-1:0] b, output logic [PW-1:0] p);
        longint best = 0;
        b = '0;
        for (int i = 0; i < N; i++)
            if (stored(i) && pwr_of(i) > best) begin
                best = pwr_of(i);
                b = BW'(i);
            end
        p = PW'(best);
        for (int i = 0; i < N; i++) if (stored(i)) mem_m[i] = pwr_of(i);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            re_a[i] = 0;
            im_a[i] = 0;
        end
    endtask

    task automatic drive_bin(int i);
        complex_t c;
        c.re = DW'(re_a[i]);
        c.im = DW'(im_a[i]);
        fft_if.data = c;
    endtask

    task automatic run_frame(input bit gaps, input bit poke, output int tmo, output int viol);
        int i = 0, cyc = 0;
        bit acc;
        tmo = 0;
        viol = 0;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        while (i < N && cyc < 2000) begin
            fft_if.valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            drive_bin(i);
            start_i = poke && $urandom_range(0, 3) == 0;
            rd_en_i = poke;
            rd_addr_i = BW'($urandom);
            if (fft_if.ready !== 1'b1 || rd_valid_o !== 1'b0) viol++;
            acc = fft_if.valid && fft_if.ready;
            @(posedge clk_i); #1;
            if (acc) i++;
            cyc++;
        end
        fft_if.valid = 1'b0;
        start_i = 1'b0;
        rd_en_i = 1'b0;
        if (i < N) tmo++;
        cyc = 0;
        while (busy_o !== 1'b0 && cyc < 20) begin
            if (fft_if.ready !== 1'b0) viol++;
            @(posedge clk_i); #1;
            cyc++;
        end
        if (busy_o !== 1'b0) tmo++;
    endtask

    task automatic read_bin(input int a, output logic v, output logic [PW-1:0] d);
        rd_en_i = 1'b1;
        rd_addr_i = BW'(a);
        @(posedge clk_i); #1;
        rd_en_i = 1'b0;
        v = rd_valid_o;
        d = rd_data_o;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        n_checks++;
        if ({busy_o, fft_if.ready, frame_done_o, rd_valid_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/ready/done/rdv %b, want 0000", {busy_o, fft_if.ready, frame_done_o, rd_valid_o});
        end
        n_checks++;
        if (peak_bin_o !== '0 || peak_pwr_o !== '0) begin
            n_fail++;
            $display("FAIL reset_peak: got bin %0d pwr %0d, want 0 0", peak_bin_o, peak_pwr_o);
        end
    endtask

    task automatic test_tone(input int bin, input bit gaps, input string name);
        int tmo, viol, d0;
        logic [BW-1:0] eb;
        logic [PW-1:0] ep, d;
        logic v;
        clear_frame();
        re_a[bin] = 100;
        im_a[bin] = -200;
        d0 = done_cnt;
        run_frame(gaps, gaps, tmo, viol);
        model_peak(eb, ep);
        n_checks++;
        if (tmo != 0 || viol != 0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL %s_status: got timeouts %0d violations %0d done %0d, want 0 0 1", name, tmo, viol, done_cnt - d0);
        end
        n_checks++;
        if (peak_bin_o !== eb || peak_pwr_o !== ep) begin
            n_fail++;
            $display("FAIL %s_peak: got bin %0d pwr %0d, want bin %0d pwr %0d", name, peak_bin_o, peak_pwr_o, eb, ep);
        end
        for (int i = 0; i < N; i++) begin
            read_bin(i, v, d);
            n_checks++;
            if (v !== 1'b1 || d !== exp_rd(i)) begin
                n_fail++;
                $display("FAIL %s_read[%0d]: got valid %b data %0d, want 1 %0d", name, i, v, d, exp_rd(i));
            end
        end
    endtask

    task automatic test_read_hold();
        logic v;
        logic [PW-1:0] d;
        read_bin(3, v, d);
        @(posedge clk_i); #1;
        n_checks++;
        if (rd_valid_o !== 1'b0 || rd_data_o !== exp_rd(3)) begin
            n_fail++;
            $display("FAIL read_hold: got valid %b data %0d, want 0 %0d", rd_valid_o, rd_data_o, exp_rd(3));
        end
    endtask

    task automatic test_pattern(input int kind, input string name);
        int tmo, viol, d0;
        logic [BW-1:0] eb;
        logic [PW-1:0] ep, d;
        logic v;
        clear_frame();
        if (kind == 0) begin
            re_a[0] = -32768;
            im_a[0] = -32768;
        end else if (kind == 1) begin
            re_a[2] = 300; im_a[2] = 400;
            re_a[5] = 300; im_a[5] = 400;
        end else begin
            for (int i = 0; i < N; i++) begin
                re_a[i] = int'($urandom_range(0, 65535)) - 32768;
                im_a[i] = int'($urandom_range(0, 65535)) - 32768;
            end
        end
        d0 = done_cnt;
        run_frame(kind == 2, 1'b0, tmo, viol);
        model_peak(eb, ep);
        n_checks++;
        if (tmo != 0 || viol != 0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL %s_status: got timeouts %0d violations %0d done %0d, want 0 0 1", name, tmo, viol, done_cnt - d0);
        end
        n_checks++;
        if (peak_bin_o !== eb || peak_pwr_o !== ep) begin
            n_fail++;
            $display("FAIL %s_peak: got bin %0d pwr %0h, want bin %0d pwr %0h", name, peak_bin_o, peak_pwr_o, eb, ep);
        end
        for (int i = 0; i < N; i++) begin
            read_bin(i, v, d);
            n_checks++;
            if (v !== 1'b1 || d !== exp_rd(i)) begin
                n_fail++;
                $display("FAIL %s_read[%0d]: got valid %b data %0h, want 1 %0h", name, i, v, d, exp_rd(i));
            end
        end
    endtask

    task automatic test_abort();
        int cnt = 0, cyc = 0, tmo, viol, d0;
        bit acc;
        logic [BW-1:0] eb;
        logic [PW-1:0] ep;
        d0 = done_cnt;
        for (int i = 0; i < N; i++) begin
            re_a[i] = int'($urandom_range(1000, 30000));
            im_a[i] = int'($urandom_range(1000, 30000));
        end
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        while (cnt < 7 && cyc < 50) begin
            fft_if.valid = 1'b1;
            drive_bin(cnt);
            acc = fft_if.ready;
            @(posedge clk_i); #1;
            if (acc) cnt++;
            cyc++;
        end
        fft_if.valid = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || fft_if.ready !== 1'b0 || peak_bin_o !== '0 || peak_pwr_o !== '0) begin
            n_fail++;
            $display("FAIL abort_reset: got busy %b ready %b bin %0d pwr %0d, want 0 0 0 0", busy_o, fft_if.ready, peak_bin_o, peak_pwr_o);
        end
        clear_frame();
        re_a[9] = 100;
        im_a[9] = -200;
        run_frame(1'b0, 1'b0, tmo, viol);
        model_peak(eb, ep);
        n_checks++;
        if (tmo != 0 || viol != 0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL abort_status: got timeouts %0d violations %0d done %0d, want 0 0 1", tmo, viol, done_cnt - d0);
        end
        n_checks++;
        if (peak_bin_o !== eb || peak_pwr_o !== ep) begin
            n_fail++;
            $display("FAIL abort_peak: got bin %0d pwr %0d, want bin %0d pwr %0d", peak_bin_o, peak_pwr_o, eb, ep);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        rd_en_i = 1'b0;
        rd_addr_i = '0;
        fft_if.valid = 1'b0;
        fft_if.data = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        test_reset();
        test_tone(3, 1'b0, "tone");
        test_read_hold();
        test_tone(3, 1'b1, "backpressure");
        test_pattern(0, "extreme");
        test_pattern(1, "tie");
        test_pattern(2, "random_a");
        test_pattern(2, "random_b");
        test_abort();
        test_tone(12, 1'b0, "tone12");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
